// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU memory bridge: the 32-bit bus word and the
// bridge state encoding.
package hs_npu_pkg;

    typedef logic [31:0] uword;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR,
        DONE
    } hs_npu_mem_bridge_state_t;

endpackage

// File: rtl/hs_npu_mem_bridge.sv
// Bridges NPU line-wide reads/writes onto a pipelined Avalon-MM master,
// issuing one bus word per accepted command and reassembling read lines.
module hs_npu_mem_bridge
    import hs_npu_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned WORD_STRIDE    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            npu_read_ready_i,
    input  logic                            npu_write_valid_i,
    input  uword                            npu_address_i,
    input  uword [WORDS_PER_LINE-1:0]       npu_data_i,
    output logic                            npu_valid_o,
    output uword [WORDS_PER_LINE-1:0]       npu_data_o,
    output uword                            avm_address,
    output logic                            avm_read,
    output logic                            avm_write,
    output uword                            avm_writedata,
    input  logic                            avm_waitrequest,
    input  uword                            avm_readdata,
    input  logic                            avm_readdatavalid
);

    localparam int unsigned   CW   = $clog2(WORDS_PER_LINE + 1);
    localparam int unsigned   IW   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [CW-1:0] FULL = CW'(WORDS_PER_LINE);
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    hs_npu_mem_bridge_state_t   state_q, state_d;
    logic                       armed_q, armed_d;
    uword                       base_q;
    uword [WORDS_PER_LINE-1:0]  wr_data_q;
    logic [CW-1:0]              issue_q, issue_d;
    logic [CW-1:0]              recv_q, recv_d;
    logic                       load_base;
    logic                       rd_store;
    logic [IW-1:0]              issue_idx;
    logic [IW-1:0]              recv_idx;
    uword                       word_addr;

    assign issue_idx = issue_q[IW-1:0];
    assign recv_idx  = recv_q[IW-1:0];
    assign word_addr = base_q + uword'(issue_q) * uword'(WORD_STRIDE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b1;
            base_q     <= '0;
            wr_data_q  <= '0;
            issue_q    <= '0;
            recv_q     <= '0;
            npu_data_o <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
            if (load_base) begin
                base_q <= npu_address_i;
                if (npu_write_valid_i) begin
                    wr_data_q <= npu_data_i;
                end
            end
            if (rd_store) begin
                npu_data_o[recv_idx] <= avm_readdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q;
        recv_d        = recv_q;
        load_base     = 1'b0;
        rd_store      = 1'b0;
        npu_valid_o   = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;

        // Responses are collected in both read states so one arriving in the
        // same cycle as the final accept is still counted before deciding DONE.
        if ((state_q == RD_ISSUE || state_q == RD_DRAIN) && avm_readdatavalid
            && recv_q != FULL) begin
            rd_store = 1'b1;
            recv_d   = recv_q + ONE;
        end

        case (state_q)
            IDLE: begin
                issue_d = '0;
                recv_d  = '0;
                if (armed_q && npu_write_valid_i) begin
                    load_base = 1'b1;
                    state_d   = WR;
                end else if (armed_q && npu_read_ready_i) begin
                    load_base = 1'b1;
                    state_d   = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                avm_read    = 1'b1;
                avm_address = word_addr;
                if (!avm_waitrequest) begin
                    issue_d = issue_q + ONE;
                    if (issue_q == LAST) begin
                        state_d = (recv_d == FULL) ? DONE : RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (recv_d == FULL) begin
                    state_d = DONE;
                end
            end
            WR: begin
                avm_write     = 1'b1;
                avm_address   = word_addr;
                avm_writedata = wr_data_q[issue_idx];
                if (!avm_waitrequest) begin
                    issue_d = issue_q + ONE;
                    if (issue_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                npu_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Disarm on completion so a request still held high cannot retrigger.
    always_comb begin
        armed_d = armed_q;
        if (state_d == DONE && state_q != DONE) begin
            armed_d = 1'b0;
        end else if (!npu_read_ready_i && !npu_write_valid_i) begin
            armed_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_npu_mem_bridge.sv
// Directed bench for hs_npu_mem_bridge with a one-cycle-latency Avalon slave
// model and hand-computed expectations.
module tb_hs_npu_mem_bridge;
    import hs_npu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       npu_read_ready_i;
    logic       npu_write_valid_i;
    uword       npu_address_i;
    uword [1:0] npu_data_i;
    logic       npu_valid_o;
    uword [1:0] npu_data_o;
    uword       avm_address;
    logic       avm_read;
    logic       avm_write;
    uword       avm_writedata;
    logic       avm_waitrequest;
    uword       avm_readdata;
    logic       avm_readdatavalid;

    hs_npu_mem_bridge #(
        .WORDS_PER_LINE (2),
        .WORD_STRIDE    (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .npu_read_ready_i  (npu_read_ready_i),
        .npu_write_valid_i (npu_write_valid_i),
        .npu_address_i     (npu_address_i),
        .npu_data_i        (npu_data_i),
        .npu_valid_o       (npu_valid_o),
        .npu_data_o        (npu_data_o),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   excl_viol = 0;
    int   v0;
    int   n;
    logic resp_en;
    uword cmd_addr[$];
    bit   cmd_wr[$];
    uword cmd_data[$];
    uword pend[$];

    task automatic check(input string tag, input uword got, input uword exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic uword rd_value(input uword a);
        case (a)
            32'h0000_0100: return 32'h0000_000A;
            32'h0000_0104: return 32'h0000_000B;
            default:       return a + 32'h0000_1000;
        endcase
    endfunction

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int cnt);
        cnt = 0;
        while (cnt < max_cyc) begin
            @(negedge clk);
            cnt++;
            if (npu_valid_o) return;
        end
        cnt = -1;
    endtask

    task automatic clear_log();
        cmd_addr.delete();
        cmd_wr.delete();
        cmd_data.delete();
    endtask

    // Mid-cycle monitor: a command seen without waitrequest is accepted at the next edge.
    always @(negedge clk) begin
        if (avm_read && avm_write) excl_viol++;
        if (npu_valid_o) valid_cnt++;
        if (!avm_waitrequest && (avm_read || avm_write)) begin
            cmd_addr.push_back(avm_address);
            cmd_wr.push_back(avm_write);
            cmd_data.push_back(avm_writedata);
            if (avm_read) pend.push_back(rd_value(avm_address));
        end
    end

    always @(posedge clk) begin
        #2;
        if (resp_en && pend.size() > 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend.pop_front();
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
    end

    initial begin
        rst_n             = 1'b0;
        npu_read_ready_i  = 1'b0;
        npu_write_valid_i = 1'b0;
        npu_address_i     = '0;
        npu_data_i        = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        resp_en           = 1'b1;

        cyc(2);
        @(negedge clk);
        check("rst_valid", uword'(npu_valid_o), 0);
        check("rst_read", uword'(avm_read), 0);
        check("rst_write", uword'(avm_write), 0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_data0", npu_data_o[0], 0);
        check("rst_data1", npu_data_o[1], 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // Basic read, request held high afterwards
        clear_log();
        v0 = valid_cnt;
        npu_address_i    = 32'h0000_0100;
        npu_read_ready_i = 1'b1;
        wait_valid(20, n);
        check("rd_latency", uword'(n - 1), 4);
        cyc(4);
        check("rd_hold_cmds", uword'(cmd_addr.size()), 2);
        check("rd_addr0", cmd_addr[0], 32'h0000_0100);
        check("rd_addr1", cmd_addr[1], 32'h0000_0104);
        check("rd_is_read", uword'(cmd_wr[0] | cmd_wr[1]), 0);
        check("rd_data0", npu_data_o[0], 32'h0000_000A);
        check("rd_data1", npu_data_o[1], 32'h0000_000B);
        check("rd_pulses", uword'(valid_cnt - v0), 1);
        npu_read_ready_i = 1'b0;
        cyc(2);

        // Write stalled three cycles on word 0
        clear_log();
        v0 = valid_cnt;
        npu_address_i     = 32'h0000_0200;
        npu_data_i[0]     = 32'h0000_0011;
        npu_data_i[1]     = 32'h0000_0022;
        npu_write_valid_i = 1'b1;
        avm_waitrequest   = 1'b1;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("wr_stall_cmd", uword'(avm_write), 1);
            check("wr_stall_addr", avm_address, 32'h0000_0200);
            check("wr_stall_data", avm_writedata, 32'h0000_0011);
        end
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_valid(20, n);
        check("wr_done", uword'(n > 0), 1);
        npu_write_valid_i = 1'b0;
        cyc(2);
        check("wr_cmds", uword'(cmd_addr.size()), 2);
        check("wr_addr0", cmd_addr[0], 32'h0000_0200);
        check("wr_addr1", cmd_addr[1], 32'h0000_0204);
        check("wr_wdata0", cmd_data[0], 32'h0000_0011);
        check("wr_wdata1", cmd_data[1], 32'h0000_0022);
        check("wr_is_write", uword'(cmd_wr[0] & cmd_wr[1]), 1);
        check("wr_pulses", uword'(valid_cnt - v0), 1);
        check("wr_keeps_rd0", npu_data_o[0], 32'h0000_000A);
        check("wr_keeps_rd1", npu_data_o[1], 32'h0000_000B);

        // Simultaneous read and write: write wins, read needs a re-raise
        clear_log();
        v0 = valid_cnt;
        npu_address_i     = 32'h0000_0400;
        npu_data_i[0]     = 32'h0000_0033;
        npu_data_i[1]     = 32'h0000_0044;
        npu_read_ready_i  = 1'b1;
        npu_write_valid_i = 1'b1;
        wait_valid(20, n);
        check("both_done", uword'(n > 0), 1);
        cyc(3);
        check("both_cmds", uword'(cmd_addr.size()), 2);
        check("both_first_wr", uword'(cmd_wr[0] & cmd_wr[1]), 1);
        check("both_wdata1", cmd_data[1], 32'h0000_0044);
        npu_read_ready_i  = 1'b0;
        npu_write_valid_i = 1'b0;
        cyc(1);
        npu_read_ready_i = 1'b1;
        wait_valid(20, n);
        check("both_rd_done", uword'(n > 0), 1);
        npu_read_ready_i = 1'b0;
        cyc(2);
        check("both_total_cmds", uword'(cmd_addr.size()), 4);
        check("both_rd_kind", uword'(cmd_wr[2] | cmd_wr[3]), 0);
        check("both_rd_addr1", cmd_addr[3], 32'h0000_0404);
        check("both_rd_data0", npu_data_o[0], 32'h0000_1400);
        check("both_rd_data1", npu_data_o[1], 32'h0000_1404);
        check("both_pulses", uword'(valid_cnt - v0), 2);

        // Address wrap
        clear_log();
        npu_address_i    = 32'hFFFF_FFFC;
        npu_read_ready_i = 1'b1;
        wait_valid(20, n);
        check("wrap_done", uword'(n > 0), 1);
        npu_read_ready_i = 1'b0;
        cyc(2);
        check("wrap_addr0", cmd_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr1", cmd_addr[1], 32'h0000_0000);
        check("wrap_data0", npu_data_o[0], 32'h0000_0FFC);
        check("wrap_data1", npu_data_o[1], 32'h0000_1000);

        // Reset in RD_DRAIN with one response outstanding
        clear_log();
        v0 = valid_cnt;
        resp_en          = 1'b0;
        npu_address_i    = 32'h0000_0300;
        npu_read_ready_i = 1'b1;
        cyc(1);
        npu_read_ready_i = 1'b0;
        cyc(3);
        check("drain_pending", uword'(pend.size()), 2);
        check("drain_no_cmd", uword'(avm_read), 0);
        resp_en = 1'b1;
        cyc(1);
        resp_en = 1'b0;
        @(negedge clk);
        check("drain_partial", npu_data_o[0], 32'h0000_1300);
        check("drain_one_left", uword'(pend.size()), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", uword'(npu_valid_o), 0);
        check("mid_rst_read", uword'(avm_read), 0);
        check("mid_rst_addr", avm_address, 0);
        check("mid_rst_data0", npu_data_o[0], 0);
        check("mid_rst_data1", npu_data_o[1], 0);
        cyc(1);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        cyc(3);
        check("late_consumed", uword'(pend.size()), 0);
        check("late_ignored0", npu_data_o[0], 0);
        check("late_ignored1", npu_data_o[1], 0);
        check("late_no_pulse", uword'(valid_cnt - v0), 0);
        check("late_no_cmd", uword'(cmd_addr.size()), 2);

        clear_log();
        npu_address_i    = 32'h0000_0100;
        npu_read_ready_i = 1'b1;
        wait_valid(20, n);
        check("post_rst_lat", uword'(n - 1), 4);
        npu_read_ready_i = 1'b0;
        cyc(2);
        check("post_rst_cmds", uword'(cmd_addr.size()), 2);
        check("post_rst_data0", npu_data_o[0], 32'h0000_000A);
        check("post_rst_data1", npu_data_o[1], 32'h0000_000B);

        check("rd_wr_exclusive", uword'(excl_viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hs_npu_mem_bridge.md
HS_NPU_MEM_BRIDGE -- requirements
Module: hs_npu_mem_bridge

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 2, giving 32-bit words per NPU memory line (SIZE x INT8 / 32).
REQ-002 SHALL have parameter WORD_STRIDE, default 4, giving the byte increment between consecutive words of a line.
REQ-003 SHALL have one clock and an asynchronous active-low reset, named as the codebase does: clk  input  1  clock; rst_n  input  1  async active-low reset.
REQ-004 npu_read_ready_i  input  1  NPU requests a line read (level).
REQ-005 npu_write_valid_i  input  1  NPU requests a line write (level).
REQ-006 npu_address_i  input  uword  byte address of word 0 of the line.
REQ-007 npu_data_i  input  uword[WORDS_PER_LINE]  line to write.
REQ-008 npu_valid_o  output  1  one-cycle completion pulse for a read or a write.
REQ-009 npu_data_o  output  uword[WORDS_PER_LINE]  assembled read line.
REQ-010 avm_address  output  uword  Avalon-MM byte address.
REQ-011 avm_read / avm_write  output  1 each  Avalon-MM read and write commands.
REQ-012 avm_writedata  output  uword  Avalon-MM write data.
REQ-013 avm_waitrequest  input  1  slave stall; a command is accepted on any cycle where it is asserted and waitrequest is low.
REQ-014 avm_readdata  input  uword; avm_readdatavalid  input  1  pipelined read responses, returned in issue order.

Function
REQ-015 States SHALL be IDLE, RD_ISSUE, RD_DRAIN, WR, DONE.
REQ-016 IDLE: if armed and npu_write_valid_i, SHALL latch address and npu_data_i, then go to WR. Write has priority over a simultaneous read.
REQ-017 IDLE: else if armed and npu_read_ready_i, SHALL latch the address and go to RD_ISSUE.
REQ-018 Armed SHALL be set after reset and whenever both request inputs are low. It SHALL be cleared on entering DONE. A request held high through completion therefore starts no second transaction.
REQ-019 RD_ISSUE SHALL assert avm_read with avm_address = base + issue_cnt*WORD_STRIDE.
REQ-020 In RD_ISSUE, issue_cnt SHALL increment on each accepted command. Address and command SHALL be held stable while waitrequest is high.
REQ-021 After WORDS_PER_LINE accepted reads, the block SHALL go to RD_DRAIN, or to DONE if all responses have already arrived.
REQ-022 In RD_ISSUE and RD_DRAIN, each avm_readdatavalid SHALL store avm_readdata into npu_data_o[recv_cnt] and increment recv_cnt. A response arriving in the same cycle as a command is accepted SHALL be handled.
REQ-023 RD_DRAIN SHALL go to DONE in the cycle after recv_cnt reaches WORDS_PER_LINE.
REQ-024 WR SHALL assert avm_write with avm_writedata = latched word[issue_cnt] and address = base + issue_cnt*WORD_STRIDE, held stable while waitrequest is high.
REQ-025 WR SHALL go to DONE after the last word is accepted.
REQ-026 DONE SHALL assert npu_valid_o for exactly one cycle, then return to IDLE.
REQ-027 npu_data_o SHALL hold its value until the next read response overwrites it.
REQ-028 avm_read and avm_write SHALL never be asserted together, and neither SHALL be asserted in IDLE or DONE.
REQ-029 avm_readdatavalid in IDLE, WR or DONE SHALL be ignored.
REQ-030 Counter width SHALL be $clog2(WORDS_PER_LINE+1).
REQ-031 Address arithmetic SHALL wrap modulo 2^32.
REQ-032 Minimum read latency with zero wait and one-cycle response SHALL be WORDS_PER_LINE+2 cycles from request to npu_valid_o.

Reset
REQ-033 Asserting rst_n low, including mid-transaction, SHALL asynchronously force: state IDLE, armed 1, counters 0, npu_valid_o 0, avm_read 0, avm_write 0, avm_address 0, avm_writedata 0, npu_data_o all 0.
REQ-034 Responses to reads issued before reset SHALL be discarded per REQ-029.

Structure
REQ-035 The state enum hs_npu_mem_bridge_state_t SHALL live in hs_npu_pkg alongside uword. No sub-module; a single flat module.

Verification
REQ-036 Read: addr 0x100, zero wait, responses 0xA, 0xB -> reads at 0x100 and 0x104, npu_data_o={0xA,0xB}, one npu_valid_o pulse.
REQ-037 Write: addr 0x200, data {0x11,0x22}, waitrequest high 3 cycles on word 0 -> address and data stable while stalled, writes at 0x200=0x11 and 0x204=0x22, then one valid pulse.
REQ-038 Read and write requested in the same cycle -> write executes first. The read executes only after both requests drop and the read is re-raised.
REQ-039 Request held high after npu_valid_o -> no new avm command until the request drops for at least one cycle.
REQ-040 Reset asserted in RD_DRAIN with one response pending -> outputs at reset values, the late readdatavalid is ignored, and the next read completes correctly.
REQ-041 Address 0xFFFFFFFC read -> second word address wraps to 0x00000000.
